// File: rtl/pattern_seq.sv
// Pattern sequencer: writable table streamed out over valid/ready.
// Supports wrap, one-shot and ping-pong addressing with start/stop control.
module pattern_seq #(
  parameter int unsigned ADDR_WIDTH = 2,
  parameter int unsigned ADDR_COUNT = 1 << ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_wr_en,
  input  logic [ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0] i_wr_data,
  input  logic                  i_start,
  input  logic                  i_stop,
  input  logic [1:0]            i_mode,
  input  logic [ADDR_WIDTH-1:0] i_last,
  input  logic                  i_ready,
  output logic                  o_valid,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic [ADDR_WIDTH-1:0] o_addr,
  output logic                  o_busy,
  output logic                  o_done
);

  localparam int unsigned MODE_W = 2;
  localparam logic [MODE_W-1:0] MODE_ONESHOT  = MODE_W'(1);
  localparam logic [MODE_W-1:0] MODE_PINGPONG = MODE_W'(2);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic                  dir_down_q, dir_down_d;
  logic [MODE_W-1:0]     mode_q, mode_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic [DATA_WIDTH-1:0] table_q [ADDR_COUNT];

  // Table storage: reset reloads entry i with i+1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int unsigned i = 0; i < ADDR_COUNT; i++) begin
        table_q[i] <= DATA_WIDTH'(i + 1);
      end
    end else if (i_wr_en) begin
      table_q[i_wr_addr] <= i_wr_data;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= '0;
      dir_down_q  <= 1'b0;
      mode_q      <= '0;
      last_q      <= '0;
      stop_pend_q <= 1'b0;
      valid_q     <= 1'b0;
      data_q      <= '0;
      addr_q      <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      dir_down_q  <= dir_down_d;
      mode_q      <= mode_d;
      last_q      <= last_d;
      stop_pend_q <= stop_pend_d;
      valid_q     <= valid_d;
      data_q      <= data_d;
      addr_q      <= addr_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    dir_down_d  = dir_down_q;
    mode_d      = mode_q;
    last_d      = last_q;
    stop_pend_d = stop_pend_q;
    valid_d     = valid_q;
    data_d      = data_q;
    addr_d      = addr_q;
    done_d      = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (i_start && !i_stop) begin
          state_d     = S_RUN;
          ptr_d       = '0;
          dir_down_d  = 1'b0;
          mode_d      = i_mode;
          last_d      = i_last;
          stop_pend_d = 1'b0;
        end
      end
      S_RUN: begin
        // A stop is remembered until the pending beat has been accepted.
        if (i_stop || stop_pend_q) begin
          if (!valid_q || i_ready) begin
            valid_d     = 1'b0;
            stop_pend_d = 1'b0;
            state_d     = S_IDLE;
          end else begin
            stop_pend_d = 1'b1;
          end
        end else if (!valid_q || i_ready) begin
          data_d  = table_q[ptr_q];
          addr_d  = ptr_q;
          valid_d = 1'b1;
          case (mode_q)
            MODE_ONESHOT: begin
              if (ptr_q == last_q) state_d = S_DRAIN;
              else                 ptr_d   = ptr_q + ADDR_WIDTH'(1);
            end
            MODE_PINGPONG: begin
              // Endpoints are emitted once per turn.
              if (last_q == '0) begin
                ptr_d = '0;
              end else if (!dir_down_q) begin
                if (ptr_q == last_q) begin
                  dir_down_d = 1'b1;
                  ptr_d      = ptr_q - ADDR_WIDTH'(1);
                end else begin
                  ptr_d      = ptr_q + ADDR_WIDTH'(1);
                end
              end else begin
                if (ptr_q == '0) begin
                  dir_down_d = 1'b0;
                  ptr_d      = ADDR_WIDTH'(1);
                end else begin
                  ptr_d      = ptr_q - ADDR_WIDTH'(1);
                end
              end
            end
            default: begin
              ptr_d = (ptr_q == last_q) ? '0 : ptr_q + ADDR_WIDTH'(1);
            end
          endcase
        end
      end
      S_DRAIN: begin
        if (i_ready) begin
          valid_d = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  assign o_valid = valid_q;
  assign o_data  = data_q;
  assign o_addr  = addr_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_pattern_seq.sv
// Scoreboard bench for pattern_seq: expected beats come from an arithmetic
// address model plus a shadow table; a negedge monitor pops and compares.
module tb_pattern_seq;

  localparam int unsigned AW = 2;
  localparam int unsigned DW = 32;
  localparam int unsigned N  = 1 << AW;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } beat_t;

  logic          clk = 1'b0;
  logic          i_rst = 1'b1;
  logic          i_wr_en = 1'b0;
  logic [AW-1:0] i_wr_addr = '0;
  logic [DW-1:0] i_wr_data = '0;
  logic          i_start = 1'b0;
  logic          i_stop = 1'b0;
  logic [1:0]    i_mode = '0;
  logic [AW-1:0] i_last = '0;
  logic          i_ready = 1'b0;
  logic          o_valid;
  logic [DW-1:0] o_data;
  logic [AW-1:0] o_addr;
  logic          o_busy;
  logic          o_done;

  pattern_seq #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_wr_en(i_wr_en), .i_wr_addr(i_wr_addr),
    .i_wr_data(i_wr_data), .i_start(i_start), .i_stop(i_stop),
    .i_mode(i_mode), .i_last(i_last), .i_ready(i_ready), .o_valid(o_valid),
    .o_data(o_data), .o_addr(o_addr), .o_busy(o_busy), .o_done(o_done)
  );

  always #5 clk = ~clk;

  beat_t         exp_q[$];
  logic [DW-1:0] tbl [N];
  int            checks = 0;
  int            failures = 0;
  int            accepted = 0;
  int            done_cnt = 0;
  bit            hold_pend = 1'b0;
  beat_t         hold_b;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic int ref_addr(input int mode, input int last, input int k);
    int p;
    if (mode == 2) begin
      if (last == 0) return 0;
      p = k % (2 * last);
      return (p <= last) ? p : 2 * last - p;
    end
    return k % (last + 1);
  endfunction

  task automatic tbl_init();
    for (int i = 0; i < N; i++) tbl[i] = DW'(i + 1);
  endtask

  // Monitor: compare each accepted beat, and check held beats stay stable.
  always @(negedge clk) begin
    beat_t e;
    if (i_rst) begin
      hold_pend = 1'b0;
    end else begin
      if (o_done) done_cnt++;
      if (hold_pend) begin
        check("hold_valid", 64'(o_valid), 64'd1);
        check("hold_data", 64'(o_data), 64'(hold_b.data));
        check("hold_addr", 64'(o_addr), 64'(hold_b.addr));
      end
      if (o_valid) begin
        if (i_ready) begin
          hold_pend = 1'b0;
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL extra_beat actual addr=%0h data=%0h expected no beat", o_addr, o_data);
          end else begin
            e = exp_q.pop_front();
            if (o_addr !== e.addr || o_data !== e.data) begin
              failures++;
              $display("FAIL beat actual addr=%0h data=%0h expected addr=%0h data=%0h",
                       o_addr, o_data, e.addr, e.data);
            end
          end
          accepted++;
        end else begin
          hold_pend = 1'b1;
          hold_b    = '{addr: o_addr, data: o_data};
        end
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  // One run: push the expected stream, start, stream with random ready and
  // noise on ignored inputs, then finish via done (one-shot) or stop.
  task automatic run(input int mode, input int last, input int nbeats, input int ready_pct,
                     input int wc, input int wa, input logic [DW-1:0] wd);
    int    target, n_exp, cyc, a;
    beat_t b, first_b;
    exp_q.delete();
    accepted = 0;
    done_cnt = 0;
    target = (mode == 1) ? last + 1 : nbeats;
    n_exp  = (mode == 1) ? last + 1 : nbeats + 2;
    for (int k = 0; k < n_exp; k++) begin
      a = ref_addr(mode, last, k);
      b.addr = AW'(a);
      b.data = (wc >= 0 && a == wa && k + 2 > wc) ? wd : tbl[a];
      exp_q.push_back(b);
    end
    first_b = exp_q[0];
    i_start = 1'b1;
    i_mode  = 2'(mode);
    i_last  = AW'(last);
    i_ready = ($urandom_range(99) < ready_pct);
    cyc = 0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      i_start = 1'b0;
      i_wr_en = 1'b0;
      if (cyc == 1) check("busy_after_start", 64'(o_busy), 64'd1);
      if (cyc == 2) begin
        check("start_valid", 64'(o_valid), 64'd1);
        check("start_data", 64'(o_data), 64'(first_b.data));
        check("start_addr", 64'(o_addr), 64'(first_b.addr));
      end
      if (accepted >= target) break;
      if (cyc > 2000) begin
        check("run_timeout", 64'(accepted), 64'(target));
        break;
      end
      if (cyc == wc - 1) begin
        i_wr_en   = 1'b1;
        i_wr_addr = AW'(wa);
        i_wr_data = wd;
      end
      i_ready = ($urandom_range(99) < ready_pct);
      i_start = 1'($urandom_range(1));
      i_mode  = 2'($urandom);
      i_last  = AW'($urandom);
    end
    if (ready_pct >= 100) check("throughput_cycles", 64'(cyc), 64'(target + 2));
    if (mode == 1) begin
      check("done_pulse", 64'(o_done), 64'd1);
      check("done_valid", 64'(o_valid), 64'd0);
      check("done_busy", 64'(o_busy), 64'd0);
      @(posedge clk); #1;
      check("done_single", 64'(o_done), 64'd0);
      check("done_count", 64'(done_cnt), 64'd1);
    end else begin
      i_stop  = 1'b1;
      i_ready = 1'b0;
      @(posedge clk); #1;
      i_stop = 1'b0;
      check("stop_pending_valid", 64'(o_valid), 64'd1);
      check("stop_pending_busy", 64'(o_busy), 64'd1);
      repeat ($urandom_range(2)) begin
        @(posedge clk); #1;
      end
      i_ready = 1'b1;
      @(posedge clk); #1;
      check("stop_valid", 64'(o_valid), 64'd0);
      check("stop_busy", 64'(o_busy), 64'd0);
      check("stop_beats", 64'(accepted), 64'(target + 1));
      @(posedge clk); #1;
      check("stop_no_done", 64'(done_cnt), 64'd0);
    end
    exp_q.delete();
  endtask

  task automatic idle_write(input int wa, input logic [DW-1:0] wd);
    i_wr_en   = 1'b1;
    i_wr_addr = AW'(wa);
    i_wr_data = wd;
    @(posedge clk); #1;
    i_wr_en = 1'b0;
    tbl[wa] = wd;
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout actual=running expected=finished");
    $fatal(1);
  end

  initial begin
    tbl_init();
    repeat (2) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_data", 64'(o_data), 64'd0);
    check("rst_addr", 64'(o_addr), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);

    run(0, 3, 10, 100, -1, 0, '0);
    run(1, 2, 0, 100, -1, 0, '0);
    run(1, 2, 0, 100, -1, 0, '0);
    run(1, 3, 0, 60, -1, 0, '0);
    run(2, 3, 12, 100, -1, 0, '0);
    run(2, 0, 5, 100, -1, 0, '0);
    run(2, 2, 15, 50, -1, 0, '0);
    run(3, 2, 8, 70, -1, 0, '0);
    run(0, 3, 20, 50, -1, 0, '0);

    idle_write(1, 32'hDEAD_BEEF);
    run(0, 1, 6, 100, -1, 0, '0);
    // Write index 1 on the edge that loads it: old value now, new next lap.
    run(0, 1, 6, 100, 3, 1, 32'h1234_5678);
    tbl[1] = 32'h1234_5678;

    for (int r = 0; r < 8; r++) begin
      idle_write(int'($urandom_range(N - 1)), $urandom);
      run(int'($urandom_range(3)), int'($urandom_range(N - 1)),
          int'($urandom_range(12, 4)), int'($urandom_range(100, 40)), -1, 0, '0);
    end

    // Stop wins over start in IDLE.
    i_start = 1'b1;
    i_stop  = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    i_stop  = 1'b0;
    check("start_stop_busy", 64'(o_busy), 64'd0);
    @(posedge clk); #1;
    check("start_stop_valid", 64'(o_valid), 64'd0);

    // Reset mid-run drops the beat and restores the table.
    exp_q.delete();
    for (int k = 0; k < 12; k++) exp_q.push_back('{addr: AW'(k % 4), data: tbl[k % 4]});
    i_ready = 1'b1;
    i_mode  = 2'd0;
    i_last  = AW'(3);
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk); #1;
    i_rst = 1'b0;
    check("midrst_valid", 64'(o_valid), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    check("midrst_data", 64'(o_data), 64'd0);
    exp_q.delete();
    tbl_init();
    run(1, 3, 0, 100, -1, 0, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
